// File: rtl/camera_i2c_arbiter.sv
// Round-robin owner of the shared camera I2C pad with a bus-free gap between owners,
// a hold-time watchdog, and boot gating that admits only the MIPI bridge until it finishes.
module camera_i2c_arbiter #(
  parameter int unsigned GAP_CYCLES     = 250,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic       CLK_50,
  input  logic       RESET,
  input  logic [2:0] REQ,
  input  logic [2:0] SCL_IN,
  input  logic [2:0] SDA_OE_IN,
  output logic [2:0] GNT,
  output logic       I2C_SCL,
  output logic       I2C_SDA_OE,
  output logic       BRIDGE_READY,
  output logic       TIMEOUT
);

  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  HOLD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state_q;
  logic [2:0]        gnt_q;
  logic [1:0]        owner_q;
  logic [1:0]        last_q;
  logic [2:0]        mask_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [TO_W-1:0]   hold_cnt_q;
  logic              bridge_ready_q;
  logic              timeout_q;

  logic [2:0]        elig_d;
  logic              pick_valid_d;
  logic [1:0]        pick_idx_d;

  // Until the bridge has configured itself, the sensor and VCM must stay off the bus.
  assign elig_d = (bridge_ready_q ? REQ : (REQ & 3'b001)) & ~mask_q;

  always_comb begin
    int idx;
    pick_valid_d = 1'b0;
    pick_idx_d   = 2'd0;
    idx          = 0;
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(last_q) + k) % 3;
      if (!pick_valid_d && elig_d[idx]) begin
        pick_valid_d = 1'b1;
        pick_idx_d   = 2'(idx);
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      gnt_q          <= 3'b000;
      owner_q        <= 2'd0;
      last_q         <= 2'd2;
      mask_q         <= 3'b000;
      gap_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      bridge_ready_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      // A mask lifts once the revoked requester is seen with its request low.
      mask_q    <= mask_q & REQ;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_d) begin
            state_q    <= ST_GRANT;
            gnt_q      <= 3'b001 << pick_idx_d;
            owner_q    <= pick_idx_d;
            last_q     <= pick_idx_d;
            hold_cnt_q <= '0;
          end
        end
        ST_GRANT: begin
          if (!REQ[owner_q]) begin
            state_q   <= ST_GAP;
            gnt_q     <= 3'b000;
            gap_cnt_q <= '0;
            if (owner_q == 2'd0) begin
              bridge_ready_q <= 1'b1;
            end
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q   <= ST_GAP;
            gnt_q     <= 3'b000;
            gap_cnt_q <= '0;
            timeout_q <= 1'b1;
            mask_q    <= (mask_q & REQ) | gnt_q;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 3'b000;
        end
      endcase
    end
  end

  // Pad idles released (SCL high, SDA not pulled) whenever nobody owns the bus.
  assign I2C_SCL      = (gnt_q == 3'b000) ? 1'b1 : |(gnt_q & SCL_IN);
  assign I2C_SDA_OE   = |(gnt_q & SDA_OE_IN);
  assign GNT          = gnt_q;
  assign BRIDGE_READY = bridge_ready_q;
  assign TIMEOUT      = timeout_q;

endmodule

// File: tb/tb_camera_i2c_arbiter.sv
// Scoreboard bench for camera_i2c_arbiter: stimulus queues expected grant/timeout events
// with the negedge index they must appear on; a monitor pops and checks each observed event.
module tb_camera_i2c_arbiter;

  logic       CLK_50 = 1'b0;
  logic       RESET;
  logic [2:0] REQ;
  logic [2:0] SCL_IN;
  logic [2:0] SDA_OE_IN;
  logic [2:0] GNT;
  logic       I2C_SCL;
  logic       I2C_SDA_OE;
  logic       BRIDGE_READY;
  logic       TIMEOUT;

  camera_i2c_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .CLK_50      (CLK_50),
    .RESET       (RESET),
    .REQ         (REQ),
    .SCL_IN      (SCL_IN),
    .SDA_OE_IN   (SDA_OE_IN),
    .GNT         (GNT),
    .I2C_SCL     (I2C_SCL),
    .I2C_SDA_OE  (I2C_SDA_OE),
    .BRIDGE_READY(BRIDGE_READY),
    .TIMEOUT     (TIMEOUT)
  );

  always #10 CLK_50 = ~CLK_50;

  typedef struct {
    logic [2:0] gnt;
    logic       to;
    logic       br;
    int         at;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         ncnt       = 0;
  bit         armed      = 0;
  logic [2:0] prev_gnt   = 3'b000;

  // Monitor: an event is any change of GNT or a TIMEOUT pulse.
  always @(negedge CLK_50) begin
    exp_t e;
    ncnt++;
    if (armed) begin
      if ((GNT !== prev_gnt) || (TIMEOUT !== 1'b0)) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event: cyc=%0d got GNT=%b TIMEOUT=%b BR=%b, required no event",
                   ncnt, GNT, TIMEOUT, BRIDGE_READY);
        end else begin
          e = q.pop_front();
          if (GNT !== e.gnt || TIMEOUT !== e.to || BRIDGE_READY !== e.br || ncnt != e.at) begin
            mismatched++;
            $display("FAIL %s: got GNT=%b TO=%b BR=%b cyc=%0d, required GNT=%b TO=%b BR=%b cyc=%0d",
                     e.name, GNT, TIMEOUT, BRIDGE_READY, ncnt, e.gnt, e.to, e.br, e.at);
          end else begin
            $display("event %s: GNT=%b TO=%b BR=%b cyc=%0d ok", e.name, GNT, TIMEOUT, BRIDGE_READY, ncnt);
          end
        end
      end
      if (GNT === 3'b000) begin
        compared++;
        if (I2C_SCL !== 1'b1 || I2C_SDA_OE !== 1'b0) begin
          mismatched++;
          $display("FAIL idle_pads: cyc=%0d got SCL=%b SDA_OE=%b, required SCL=1 SDA_OE=0",
                   ncnt, I2C_SCL, I2C_SDA_OE);
        end
      end
    end
    prev_gnt = GNT;
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK_50);
    #1;
  endtask

  // lat = number of rising edges from now until the one that produces the event.
  task automatic expect_ev(input logic [2:0] g, input logic t, input logic b, input int lat, input string nm);
    exp_t e;
    e.gnt = g; e.to = t; e.br = b; e.at = ncnt + 1 + lat; e.name = nm;
    q.push_back(e);
  endtask

  task automatic check_now(input string nm, input logic [5:0] got, input logic [5:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %b, required %b", nm, got, req);
    end else begin
      $display("check %s: %b ok", nm, got);
    end
  endtask

  initial begin
    RESET = 1'b1; REQ = 3'b000; SCL_IN = 3'b111; SDA_OE_IN = 3'b000;
    step(3);
    RESET = 1'b0;
    check_now("reset_state", {GNT, TIMEOUT, BRIDGE_READY, I2C_SCL}, 6'b000_0_0_1);
    check_now("reset_sda", {5'b0, I2C_SDA_OE}, 6'b0);
    armed = 1;

    // Boot gating: sensor and VCM ignored before bridge is ready.
    REQ = 3'b110;
    step(5);
    expect_ev(3'b001, 1'b0, 1'b0, 1, "boot_grant0");
    REQ = 3'b111;
    step(3);

    // Release by bridge, 4-cycle gap, 1 idle cycle, then round-robin to 1.
    expect_ev(3'b000, 1'b0, 1'b1, 1, "release0");
    expect_ev(3'b010, 1'b0, 1'b1, 6, "grant1");
    REQ = 3'b110;
    step(6);

    // Mux follows owner bit only.
    SCL_IN = 3'b101; #1; check_now("mux_scl_101", {5'b0, I2C_SCL}, 6'd0);
    SCL_IN = 3'b010; #1; check_now("mux_scl_010", {5'b0, I2C_SCL}, 6'd1);
    SDA_OE_IN = 3'b010; #1; check_now("mux_sda_010", {5'b0, I2C_SDA_OE}, 6'd1);
    SDA_OE_IN = 3'b101; #1; check_now("mux_sda_101", {5'b0, I2C_SDA_OE}, 6'd0);
    SCL_IN = 3'b111; SDA_OE_IN = 3'b000;

    expect_ev(3'b000, 1'b0, 1'b1, 1, "release1");
    expect_ev(3'b100, 1'b0, 1'b1, 6, "grant2");
    REQ = 3'b100;
    step(6);

    // Timeout on 20th grant cycle, then VCM masked while REQ stays high.
    expect_ev(3'b000, 1'b1, 1'b1, 20, "timeout2");
    step(20);
    step(10);
    REQ = 3'b000;
    step(2);
    expect_ev(3'b100, 1'b0, 1'b1, 1, "regrant2");
    REQ = 3'b100;
    step(1);

    // Release on the timeout cycle counts as a normal release; no mask.
    step(19);
    expect_ev(3'b000, 1'b0, 1'b1, 1, "release_at_timeout");
    REQ = 3'b000;
    step(1);
    expect_ev(3'b100, 1'b0, 1'b1, 5, "grant_after_late_release");
    REQ = 3'b100;
    step(5);

    // Reset mid-grant.
    expect_ev(3'b000, 1'b0, 1'b0, 1, "reset_mid_grant");
    RESET = 1'b1;
    step(1);
    check_now("reset_pads", {3'b0, BRIDGE_READY, I2C_SCL, I2C_SDA_OE}, 6'b000_0_1_0);
    RESET = 1'b0;
    REQ = 3'b000;
    step(2);

    // Bridge timeout must not set BRIDGE_READY.
    expect_ev(3'b001, 1'b0, 1'b0, 1, "grant0_again");
    expect_ev(3'b000, 1'b1, 1'b0, 21, "timeout0_no_ready");
    REQ = 3'b001;
    step(21);
    REQ = 3'b000;
    step(8);
    check_now("bridge_not_ready", {5'b0, BRIDGE_READY}, 6'd0);

    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_events: got %0d pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/camera_i2c_arbiter.md
CAMERA_I2C_ARBITER -- requirements
Module: camera_i2c_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 250, giving the bus-free time in clocks between grants (5 us at 50 MHz, minimum 1).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 2500000, giving the maximum grant hold in clocks (50 ms, minimum 2).
REQ-003 CLK_50  input  1  system clock; all logic is on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 REQ  input  3  bus requests: bit0 MIPI bridge config, bit1 camera sensor config, bit2 VCM focus.
REQ-006 SCL_IN  input  3  per-requester SCL drive level.
REQ-007 SDA_OE_IN  input  3  per-requester SDA pull-low enable (open-drain).
REQ-008 GNT  output  3  registered one-hot grant; all zero when no owner.
REQ-009 I2C_SCL  output  1  muxed SCL to the shared camera I2C pad.
REQ-010 I2C_SDA_OE  output  1  muxed SDA pull-low enable to the pad.
REQ-011 BRIDGE_READY  output  1  set once requester 0 completes a normal release.
REQ-012 TIMEOUT  output  1  one-cycle pulse on a forced revoke.

Function
REQ-013 The block SHALL implement states IDLE, GRANT and GAP.
REQ-014 In IDLE with at least one eligible request, the block SHALL enter GRANT and assert the chosen GNT bit on the next cycle (1-cycle latency).
REQ-015 Eligibility: before BRIDGE_READY, only REQ[0] is eligible; after it, all bits are eligible; a requester masked by REQ-021 is never eligible.
REQ-016 Arbitration SHALL be round-robin: the search starts at index (last_granted+1) mod 3; last_granted resets to 2, so REQ[0] wins first.
REQ-017 In GRANT, I2C_SCL SHALL equal SCL_IN[owner] and I2C_SDA_OE SHALL equal SDA_OE_IN[owner], combinationally from the registered GNT.
REQ-018 In IDLE and GAP, I2C_SCL SHALL be 1 and I2C_SDA_OE SHALL be 0.
REQ-019 Owner drops REQ in GRANT -> GNT cleared next cycle; enter GAP for exactly GAP_CYCLES cycles, then IDLE; other REQ changes are ignored during GRANT.
REQ-020 A normal release by owner 0 SHALL set BRIDGE_READY on the same edge that GNT clears; BRIDGE_READY then stays 1 until RESET.
REQ-021 The hold counter SHALL clear on grant and increment each GRANT cycle; when it reaches TIMEOUT_CYCLES-1 with REQ[owner] still high: clear GNT, pulse TIMEOUT for 1 cycle, enter GAP, and mask that requester until its REQ is observed low.
REQ-022 If REQ[owner] falls on the timeout cycle, the block SHALL treat it as a normal release: no TIMEOUT pulse, no mask, and BRIDGE_READY set if the owner is 0.
REQ-023 A timeout of owner 0 SHALL NOT set BRIDGE_READY.
REQ-024 The GAP counter SHALL be wide enough for GAP_CYCLES and the hold counter for TIMEOUT_CYCLES, with no wrap.
REQ-025 At most one GNT bit SHALL ever be high, and GNT SHALL never change directly from one owner to another without a GAP.

Reset
REQ-026 While RESET=1 on an edge: state IDLE, GNT=000, TIMEOUT=0, BRIDGE_READY=0, counters 0, masks clear, last_granted=2.
REQ-027 RESET asserted mid-GRANT or mid-GAP SHALL abort on that edge; I2C_SCL=1 and I2C_SDA_OE=0 from the next cycle.
REQ-028 The first arbitration SHALL be possible on the cycle after RESET deasserts.

Verification (bench uses GAP_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-029 Boot gating: REQ=110 after reset -> GNT stays 000; raise REQ[0] -> GNT=001 one cycle later.
REQ-030 Release and gap: owner 0 drops REQ[0] with REQ=110 -> GNT=000, BRIDGE_READY=1, I2C_SCL=1 for 4 cycles, IDLE 1 cycle, then GNT=010; the next release gives GNT=100.
REQ-031 Timeout: hold REQ=100 granted for 20 cycles -> TIMEOUT high 1 cycle, GNT=000; REQ[2] stays masked (no regrant) until it drops and is raised again.
REQ-032 Release on the timeout cycle: drop REQ on the 20th grant cycle -> TIMEOUT stays 0 and no mask is applied.
REQ-033 Mux: while GNT=010, toggle SCL_IN=x1x and SDA_OE_IN=x1x -> pads follow bit1 only; bits 0 and 2 have no effect.
REQ-034 Reset mid-grant: assert RESET while GNT=100 -> next cycle GNT=000, BRIDGE_READY=0, I2C_SCL=1, I2C_SDA_OE=0.
